// File: rtl/inst_mem_loader_if.sv
// Bus bundle for the instruction memory: byte-serial load port plus PC fetch port.
// The master side drives start/prog_ctr/load bytes; the slave side returns status and the fetched word.
interface inst_mem_loader_if #(
    parameter int AW = 11,
    parameter int IW = 9
);
    logic          start;
    logic [AW-1:0] prog_ctr;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic          ld_done;
    logic          ld_err;
    logic [AW-1:0] ld_count;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          halt;

    modport master (
        output start, prog_ctr, ld_valid, ld_data,
        input  ld_ready, ld_done, ld_err, ld_count, instr, instr_valid, halt
    );

    modport slave (
        input  start, prog_ctr, ld_valid, ld_data,
        output ld_ready, ld_done, ld_err, ld_count, instr, instr_valid, halt
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory with a byte-serial program loader and a 1-cycle registered fetch port.
// Words beyond the loaded image read back as HALT_CODE; halt is sticky until reset or a new load.
module inst_mem_loader #(
    parameter int            AW        = 11,
    parameter int            IW        = 9,
    parameter int            DEPTH     = 2 ** AW,
    parameter logic [IW-1:0] HALT_CODE = 9'h1FF
) (
    input  logic             clk,
    input  logic             reset,
    inst_mem_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    lo_q, lo_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          start_q;
    logic          halt_q, halt_d;
    logic          hit_q, ivld_q;
    logic [IW-1:0] rd_q;
    logic          xfer, start_rise, fetch_en, we, in_load, at_rest;

    logic [IW-1:0] mem [DEPTH];

    assign in_load    = (state_q == LO) || (state_q == HI);
    assign at_rest    = (state_q == IDLE) || (state_q == DONE);
    assign xfer       = bus.ld_valid && bus.ld_ready;
    // A new load only opens on a start edge, so DONE after a full image stays put while start is held.
    assign start_rise = bus.start && !start_q && at_rest;
    assign fetch_en   = !bus.start && at_rest;

    assign bus.ld_ready    = in_load && bus.start;
    assign bus.ld_done     = done_q;
    assign bus.ld_err      = err_q;
    assign bus.ld_count    = cnt_q[AW-1:0];
    assign bus.instr       = hit_q ? rd_q : HALT_CODE;
    assign bus.instr_valid = ivld_q;
    assign bus.halt        = halt_q || (ivld_q && (bus.instr == HALT_CODE));

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        done_d    = done_q;
        err_d     = err_q;
        we        = 1'b0;
        halt_d    = start_rise ? 1'b0 : bus.halt;
        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_d   = LO;
                    wr_addr_d = '0;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                end
            end
            LO: begin
                if (!bus.start) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (xfer) begin
                    lo_d    = bus.ld_data;
                    state_d = HI;
                end
            end
            HI: begin
                if (!bus.start) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    done_d  = 1'b0;
                end else if (xfer) begin
                    we        = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (bus.ld_data[7:1] != 7'd0) err_d = 1'b1;
                    if (cnt_q == (AW+1)'(DEPTH - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LO;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            halt_q    <= 1'b0;
            hit_q     <= 1'b0;
            ivld_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= bus.start;
            halt_q    <= halt_d;
            ivld_q    <= fetch_en;
            if (fetch_en) hit_q <= ({1'b0, bus.prog_ctr} < cnt_q);
        end
    end

    // Array has no reset; unloaded words are masked by hit_q instead.
    always_ff @(posedge clk) begin
        if (we && !reset) mem[wr_addr_q] <= {bus.ld_data[0], lo_q};
        if (fetch_en) rd_q <= mem[bus.prog_ctr];
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: vector table for load/fetch sequences plus
// hand-written reset, mid-load reset and full-depth load sequences.
module tb_inst_mem_loader;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    inst_mem_loader_if #(.AW(11), .IW(9)) bus ();

    inst_mem_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [10:0] pc;
        logic        v;
        logic [7:0]  d;
        logic [8:0]  e_instr;
        logic        e_iv;
        logic        e_halt;
        logic [10:0] e_cnt;
        logic        e_done;
        logic        e_err;
        logic        e_rdy;
    } vec_t;

    vec_t tab [23];

    function automatic vec_t mk(int st, int pc, int v, int d, int ei, int iv, int h,
                                int c, int dn, int er, int rd);
        vec_t r;
        r.st = 1'(st);      r.pc = 11'(pc);    r.v = 1'(v);        r.d = 8'(d);
        r.e_instr = 9'(ei); r.e_iv = 1'(iv);   r.e_halt = 1'(h);   r.e_cnt = 11'(c);
        r.e_done = 1'(dn);  r.e_err = 1'(er);  r.e_rdy = 1'(rd);
        return r;
    endfunction

    function automatic logic [8:0] w(int i);
        return 9'((i * 37 + 5) & 511);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input int pc, input logic v, input int d);
        bus.start    = st;
        bus.prog_ctr = 11'(pc);
        bus.ld_valid = v;
        bus.ld_data  = 8'(d);
    endtask

    initial begin
        bit rdy_ok;
        total = 0;
        bad   = 0;

        // sequence/table rows: st pc v d | instr iv halt cnt done err rdy
        tab[0]  = mk(1, 0, 0, 'h00, 'h1FF, 0, 0, 0, 0, 0, 1);
        tab[1]  = mk(1, 0, 1, 'h12, 'h1FF, 0, 0, 0, 0, 0, 1);
        tab[2]  = mk(1, 0, 1, 'h00, 'h1FF, 0, 0, 1, 0, 0, 1);
        tab[3]  = mk(1, 0, 1, 'h34, 'h1FF, 0, 0, 1, 0, 0, 1);
        tab[4]  = mk(1, 0, 1, 'h01, 'h1FF, 0, 0, 2, 0, 0, 1);
        tab[5]  = mk(1, 0, 1, 'hFF, 'h1FF, 0, 0, 2, 0, 0, 1);
        tab[6]  = mk(1, 0, 1, 'h01, 'h1FF, 0, 0, 3, 0, 0, 1);
        tab[7]  = mk(0, 0, 0, 'h00, 'h1FF, 0, 0, 3, 1, 0, 0);
        tab[8]  = mk(0, 0, 0, 'h00, 'h012, 1, 0, 3, 1, 0, 0);
        tab[9]  = mk(0, 1, 0, 'h00, 'h134, 1, 0, 3, 1, 0, 0);
        tab[10] = mk(0, 2, 0, 'h00, 'h1FF, 1, 1, 3, 1, 0, 0);
        tab[11] = mk(0, 3, 0, 'h00, 'h1FF, 1, 1, 3, 1, 0, 0);
        tab[12] = mk(1, 0, 0, 'h00, 'h1FF, 0, 0, 0, 0, 0, 1);
        tab[13] = mk(1, 0, 1, 'hAB, 'h1FF, 0, 0, 0, 0, 0, 1);
        tab[14] = mk(0, 0, 0, 'h00, 'h1FF, 0, 0, 0, 0, 1, 0);
        tab[15] = mk(0, 0, 0, 'h00, 'h1FF, 1, 1, 0, 0, 1, 0);
        tab[16] = mk(0, 0, 1, 'hAA, 'h1FF, 1, 1, 0, 0, 1, 0);
        tab[17] = mk(1, 0, 0, 'h00, 'h1FF, 0, 0, 0, 0, 0, 1);
        tab[18] = mk(1, 0, 1, 'h55, 'h1FF, 0, 0, 0, 0, 0, 1);
        tab[19] = mk(1, 0, 1, 'h03, 'h1FF, 0, 0, 1, 0, 1, 1);
        tab[20] = mk(0, 0, 0, 'h00, 'h1FF, 0, 0, 1, 1, 1, 0);
        tab[21] = mk(0, 0, 0, 'h00, 'h155, 1, 0, 1, 1, 1, 0);
        tab[22] = mk(0, 1, 0, 'h00, 'h1FF, 1, 1, 1, 1, 1, 0);

        // reset state, then a fetch of an unloaded address
        reset = 1'b1;
        drive(0, 5, 0, 0);
        repeat (2) step();
        chk("rst_instr", bus.instr, 'h1FF);
        chk("rst_iv", bus.instr_valid, 0);
        chk("rst_halt", bus.halt, 0);
        chk("rst_cnt", bus.ld_count, 0);
        chk("rst_done", bus.ld_done, 0);
        chk("rst_err", bus.ld_err, 0);
        chk("rst_rdy", bus.ld_ready, 0);
        reset = 1'b0;
        step();
        chk("t1_instr", bus.instr, 'h1FF);
        chk("t1_iv", bus.instr_valid, 1);
        chk("t1_halt", bus.halt, 1);

        for (int i = 0; i < 23; i++) begin
            drive(tab[i].st, int'(tab[i].pc), tab[i].v, int'(tab[i].d));
            step();
            chk($sformatf("r%0d_instr", i), bus.instr, tab[i].e_instr);
            chk($sformatf("r%0d_iv", i), bus.instr_valid, tab[i].e_iv);
            chk($sformatf("r%0d_halt", i), bus.halt, tab[i].e_halt);
            chk($sformatf("r%0d_cnt", i), bus.ld_count, tab[i].e_cnt);
            chk($sformatf("r%0d_done", i), bus.ld_done, tab[i].e_done);
            chk($sformatf("r%0d_err", i), bus.ld_err, tab[i].e_err);
            chk($sformatf("r%0d_rdy", i), bus.ld_ready, tab[i].e_rdy);
        end

        // reset while in HI after one and a half words
        drive(1, 0, 0, 0);    step();
        drive(1, 0, 1, 'h11); step();
        drive(1, 0, 1, 'h00); step();
        drive(1, 0, 1, 'h22); step();
        chk("t5_pre_cnt", bus.ld_count, 1);
        reset = 1'b1;
        drive(0, 0, 0, 0);
        step();
        chk("t5_cnt", bus.ld_count, 0);
        chk("t5_iv", bus.instr_valid, 0);
        chk("t5_halt", bus.halt, 0);
        chk("t5_done", bus.ld_done, 0);
        chk("t5_err", bus.ld_err, 0);
        reset = 1'b0;
        step();
        chk("t5_idle_iv", bus.instr_valid, 1);
        chk("t5_idle_instr", bus.instr, 'h1FF);

        // full-depth load
        drive(1, 0, 0, 0);
        step();
        rdy_ok = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            drive(1, 0, 1, int'(w(i) & 'hFF));
            #1;
            if (!bus.ld_ready) rdy_ok = 1'b0;
            step();
            drive(1, 0, 1, int'(w(i) >> 8));
            #1;
            if (!bus.ld_ready) rdy_ok = 1'b0;
            step();
        end
        chk("t6_rdy_during", int'(rdy_ok), 1);
        chk("t6_done", bus.ld_done, 1);
        chk("t6_cnt", bus.ld_count, 0);
        chk("t6_rdy_after", bus.ld_ready, 0);
        chk("t6_err", bus.ld_err, 0);
        drive(1, 0, 1, 'hEE);
        step();
        chk("t6_extra_rdy", bus.ld_ready, 0);
        chk("t6_extra_done", bus.ld_done, 1);
        chk("t6_extra_err", bus.ld_err, 0);
        drive(0, 2047, 0, 0);
        step();
        chk("t6_last_iv", bus.instr_valid, 1);
        chk("t6_last_instr", bus.instr, w(2047));
        chk("t6_last_halt", bus.halt, 0);
        drive(0, 0, 0, 0);
        step();
        chk("t6_first_instr", bus.instr, w(0));
        chk("t6_done_hold", bus.ld_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
